// File: rtl/mips_pkg.sv
// Shared encodings for the pipelined MIPS core: operand forward selects and
// the multicycle-unit sequencer state codes.
package mips_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage MIPS pipeline: operand forwarding, load-use and
// branch stalls, data-memory wait stretching and multicycle mul/div sequencing.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegE,
    input  logic [4:0] WriteRegM,
    input  logic [4:0] WriteRegW,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       MemtoRegM,
    input  logic       BranchD,
    input  logic       PCSrcD,
    input  logic       MdStartE,
    input  logic       MemReqM,
    input  logic       dmem_ready,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       ForwardAD,
    output logic       ForwardBD,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic       FlushW,
    output logic       md_busy,
    output logic       md_done
);

    localparam int CNT_W = $clog2(MD_CYCLES + 1);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0] fwd_a_e, fwd_b_e;
    logic       fwd_a_d, fwd_b_d;
    logic       lwstall, brstall, mem_wait, md_stall, stall_e, stall_d;

    // M stage wins over W so the youngest producer is forwarded.
    always_comb begin
        fwd_a_e = FWD_RF;
        if (RsE != 5'd0 && RegWriteM && WriteRegM == RsE)      fwd_a_e = FWD_MEM;
        else if (RsE != 5'd0 && RegWriteW && WriteRegW == RsE) fwd_a_e = FWD_WB;
        fwd_b_e = FWD_RF;
        if (RtE != 5'd0 && RegWriteM && WriteRegM == RtE)      fwd_b_e = FWD_MEM;
        else if (RtE != 5'd0 && RegWriteW && WriteRegW == RtE) fwd_b_e = FWD_WB;
    end

    assign fwd_a_d = (RsD != 5'd0) && RegWriteM && (WriteRegM == RsD);
    assign fwd_b_d = (RtD != 5'd0) && RegWriteM && (WriteRegM == RtD);

    assign lwstall  = MemtoRegE && (RtE == RsD || RtE == RtD);
    assign brstall  = BranchD &&
                      ((RegWriteE && (WriteRegE == RsD || WriteRegE == RtD)) ||
                       (MemtoRegM && (WriteRegM == RsD || WriteRegM == RtD)));
    assign mem_wait = MemReqM && !dmem_ready;
    assign md_stall = (state_q == MD_BUSY) || (state_q == RUN && MdStartE);
    assign stall_e  = mem_wait || md_stall;
    assign stall_d  = stall_e || lwstall || brstall;

    // A memory wait freezes the sequencer in every state, MD_DONE included.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (MdStartE && !mem_wait) begin
                    state_d = MD_BUSY;
                    cnt_d   = CNT_W'(MD_CYCLES - 2);
                end
            end
            MD_BUSY: begin
                if (!mem_wait) begin
                    if (cnt_q == '0) state_d = MD_DONE;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            MD_DONE: begin
                if (!mem_wait) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Every output is held low while reset is asserted, independent of inputs.
    assign ForwardAE = reset_n ? fwd_a_e : FWD_RF;
    assign ForwardBE = reset_n ? fwd_b_e : FWD_RF;
    assign ForwardAD = reset_n && fwd_a_d;
    assign ForwardBD = reset_n && fwd_b_d;
    assign StallM    = reset_n && mem_wait;
    assign FlushW    = reset_n && mem_wait;
    assign StallE    = reset_n && stall_e;
    assign FlushM    = reset_n && md_stall && !mem_wait;
    assign StallF    = reset_n && stall_d;
    assign StallD    = reset_n && stall_d;
    assign FlushE    = reset_n && (lwstall || brstall) && !stall_e;
    assign FlushD    = reset_n && PCSrcD && !stall_d;
    assign md_busy   = reset_n && (state_q != RUN);
    assign md_done   = reset_n && (state_q == MD_DONE);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: combinational hazard vectors from a table,
// then hand-written multicycle, memory-wait and reset sequences.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic       BranchD, PCSrcD, MdStartE, MemReqM, dmem_ready;
    logic [1:0] ForwardAE, ForwardBE;
    logic       ForwardAD, ForwardBD, StallF, StallD, StallE, StallM;
    logic       FlushD, FlushE, FlushM, FlushW, md_busy, md_done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MD_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
        .BranchD(BranchD), .PCSrcD(PCSrcD), .MdStartE(MdStartE),
        .MemReqM(MemReqM), .dmem_ready(dmem_ready),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
        .md_busy(md_busy), .md_done(md_done)
    );

    // {FAE[13:12], FBE[11:10], FAD, FBD, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW}
    logic [13:0] outv;
    assign outv = {ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD, StallE, StallM,
                   FlushD, FlushE, FlushM, FlushW};

    typedef struct {
        logic [4:0]  rsd, rtd, rse, rte, wre, wrm, wrw;
        logic        rwe, rwm, rww, mtre, mtrm, br, pc, mreq, rdy;
        logic [13:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_in();
        {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
        {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM} = '0;
        {BranchD, PCSrcD, MdStartE, MemReqM} = '0;
        dmem_ready = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vt[16];
    // per-cycle {StallE, StallM, FlushW, FlushM, md_busy, md_done}
    logic [5:0] seq_exp[9];

    initial begin
        vt[0]  = '{0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0, 0,1, 14'b00_00_0_0_0000_0000};
        vt[1]  = '{7,8,3,0, 0,3,3, 0,1,1, 0,0, 0,0, 0,1, 14'b10_00_0_0_0000_0000};
        vt[2]  = '{7,8,0,0, 0,3,3, 0,1,1, 0,0, 0,0, 0,1, 14'b00_00_0_0_0000_0000};
        vt[3]  = '{7,8,4,4, 0,9,4, 0,1,1, 0,0, 0,0, 0,1, 14'b01_01_0_0_0000_0000};
        vt[4]  = '{7,8,4,6, 0,4,4, 0,0,1, 0,0, 0,0, 0,1, 14'b01_00_0_0_0000_0000};
        vt[5]  = '{5,6,0,0, 0,5,0, 0,1,0, 0,0, 0,0, 0,1, 14'b00_00_1_0_0000_0000};
        vt[6]  = '{5,6,0,0, 0,6,0, 0,1,0, 0,0, 0,0, 0,1, 14'b00_00_0_1_0000_0000};
        vt[7]  = '{5,1,0,5, 0,0,0, 0,0,0, 1,0, 0,0, 0,1, 14'b00_00_0_0_1100_0100};
        vt[8]  = '{2,3,0,5, 0,0,0, 0,0,0, 1,0, 0,0, 0,1, 14'b00_00_0_0_0000_0000};
        vt[9]  = '{7,8,0,0, 7,0,0, 1,0,0, 0,0, 1,1, 0,1, 14'b00_00_0_0_1100_0100};
        vt[10] = '{7,8,0,0, 9,0,0, 1,0,0, 0,0, 1,1, 0,1, 14'b00_00_0_0_0000_1000};
        vt[11] = '{7,8,0,0, 0,8,0, 0,0,0, 0,1, 1,0, 0,1, 14'b00_00_0_0_1100_0100};
        vt[12] = '{0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0, 1,0, 14'b00_00_0_0_1111_0001};
        vt[13] = '{0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0, 1,1, 14'b00_00_0_0_0000_0000};
        vt[14] = '{5,1,0,5, 0,0,0, 0,0,0, 1,0, 0,0, 1,0, 14'b00_00_0_0_1111_0001};
        vt[15] = '{7,8,0,0, 0,0,0, 0,0,0, 0,0, 0,1, 1,0, 14'b00_00_0_0_1111_0001};

        // Reset: outputs low even with inputs that would otherwise assert them.
        clear_in();
        reset_n = 1'b0;
        RsE = 5'd3; RegWriteM = 1'b1; WriteRegM = 5'd3; MemReqM = 1'b1; dmem_ready = 1'b0;
        MdStartE = 1'b1; PCSrcD = 1'b1;
        repeat (2) step();
        check("reset_outs", {18'd0, outv}, 32'd0);
        check("reset_busy", {30'd0, md_busy, md_done}, 32'd0);
        clear_in();
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step();
            RsD = vt[i].rsd; RtD = vt[i].rtd; RsE = vt[i].rse; RtE = vt[i].rte;
            WriteRegE = vt[i].wre; WriteRegM = vt[i].wrm; WriteRegW = vt[i].wrw;
            RegWriteE = vt[i].rwe; RegWriteM = vt[i].rwm; RegWriteW = vt[i].rww;
            MemtoRegE = vt[i].mtre; MemtoRegM = vt[i].mtrm; BranchD = vt[i].br;
            PCSrcD = vt[i].pc; MemReqM = vt[i].mreq; dmem_ready = vt[i].rdy;
            #2;
            check($sformatf("vec%0d", i), {18'd0, outv}, {18'd0, vt[i].exp});
        end

        // Load-use: one stall cycle, then the bubble clears it.
        step(); clear_in();
        MemtoRegE = 1'b1; RtE = 5'd5; RsD = 5'd5;
        #2 check("lw_stall", {29'd0, StallF, StallD, FlushE}, 32'b111);
        step(); MemtoRegE = 1'b0; RtE = 5'd0;
        #2 check("lw_release", {29'd0, StallF, StallD, FlushE}, 32'b000);

        // Multicycle op, MdStartE held through MD_DONE (must be ignored there).
        step(); clear_in();
        MdStartE = 1'b1;
        seq_exp[0] = 6'b100100; seq_exp[1] = 6'b100110; seq_exp[2] = 6'b100110;
        seq_exp[3] = 6'b100110; seq_exp[4] = 6'b000011; seq_exp[5] = 6'b000000;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) MdStartE = 1'b0;
            #2 check($sformatf("md_c%0d", c), {26'd0, StallE, StallM, FlushW, FlushM, md_busy, md_done},
                     {26'd0, seq_exp[c]});
            step();
        end

        // Memory wait for 3 cycles in MD_BUSY freezes the counter.
        clear_in();
        MdStartE = 1'b1;
        seq_exp[0] = 6'b100100;
        seq_exp[1] = 6'b111010; seq_exp[2] = 6'b111010; seq_exp[3] = 6'b111010;
        seq_exp[4] = 6'b100110; seq_exp[5] = 6'b100110; seq_exp[6] = 6'b100110;
        seq_exp[7] = 6'b000011; seq_exp[8] = 6'b000000;
        for (int c = 0; c < 9; c++) begin
            MdStartE   = (c == 0);
            MemReqM    = (c >= 1 && c <= 3);
            dmem_ready = !(c >= 1 && c <= 3);
            #2 check($sformatf("mw_c%0d", c), {26'd0, StallE, StallM, FlushW, FlushM, md_busy, md_done},
                     {26'd0, seq_exp[c]});
            step();
        end

        // Async reset mid-op aborts with no md_done afterwards.
        clear_in();
        MdStartE = 1'b1;
        step();
        MdStartE = 1'b0;
        RsE = 5'd3; RegWriteM = 1'b1; WriteRegM = 5'd3;
        #2 check("rst_pre_busy", {31'd0, md_busy}, 32'd1);
        reset_n = 1'b0;
        #1 check("rst_outs", {18'd0, outv, md_busy, md_done}, 32'd0);
        step();
        reset_n = 1'b1;
        begin
            logic seen = 1'b0;
            for (int c = 0; c < 8; c++) begin
                step();
                seen = seen | md_done | md_busy;
            end
            check("rst_no_done", {31'd0, seen}, 32'd0);
        end
        check("rst_fwd_after", {30'd0, ForwardAE}, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
